instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: mem_req_valid  output  1  fetch request to instruction memory.
REQ-005 SHALL have port: mem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have port: mem_req_addr  output  32  word address of request.
REQ-007 SHALL have port: mem_rsp_valid  input  1  read data valid, one cycle pulse per accepted request.
REQ-008 SHALL have port: mem_rsp_data  input  32  fetched instruction word.
REQ-009 SHALL have port: instr_valid  output  1  instruction available to decoder.
REQ-010 SHALL have port: instr_ready  input  1  decoder consumes instruction.
REQ-011 SHALL have port: instruction  output  32  instruction word to decoder.
REQ-012 SHALL have port: instr_pc  output  32  address of presented instruction.
REQ-013 SHALL have port: redirect_valid  input  1  branch/jump redirect pulse.
REQ-014 SHALL have port: redirect_pc  input  32  redirect target.
REQ-015 SHALL have port: misaligned  output  1  sticky misaligned-target flag.

Function
REQ-016 SHALL hold fetch pc register; mem_req_addr = pc; pc += 4 (mod 2^32) on request handshake (valid & ready).
REQ-017 SHALL keep at most one request outstanding; FSM states IDLE, WAIT_RSP, DROP.
REQ-018 SHALL assert mem_req_valid in IDLE only when buffer count + outstanding < 2; handshake moves IDLE->WAIT_RSP.
REQ-019 SHALL hold mem_req_valid and mem_req_addr stable until handshake, except on redirect.
REQ-020 SHALL, in WAIT_RSP on mem_rsp_valid, push {mem_rsp_data, request address} into a 2-entry FIFO and return to IDLE; new request no earlier than next cycle.
REQ-021 SHALL drive instr_valid = FIFO non-empty, instruction/instr_pc = FIFO head, registered; pop on instr_valid & instr_ready.
REQ-022 SHALL allow simultaneous push and pop with count unchanged; FIFO never overflows by REQ-018.
REQ-023 SHALL, on redirect_valid, flush FIFO (instr_valid low next cycle), set pc <= redirect_pc, and deassert mem_req_valid that cycle.
REQ-024 SHALL, on redirect while a request is outstanding (WAIT_RSP or handshake in redirect cycle), enter DROP, discard that response, then IDLE.
REQ-025 SHALL discard any mem_rsp_valid arriving in a redirect cycle or with no outstanding request.
REQ-026 SHALL give redirect priority over push, pop and issue in the same cycle.
REQ-027 SHALL, with single-cycle memory (ready=1, rsp next cycle), present first instr_valid 2 cycles after first request handshake.

Reset
REQ-028 SHALL on reset: pc=RESET_PC, state IDLE, FIFO empty, instr_valid=0, mem_req_valid=0, instruction=0, instr_pc=0, misaligned=0.
REQ-029 SHALL assert mem_req_valid with addr RESET_PC in first cycle after reset deasserts.
REQ-030 SHALL ignore responses to requests issued before a mid-operation reset.

Configuration
REQ-031 SHALL, with FETCH_ALIGN_CHECK_EN defined, on redirect_pc[1:0] != 0 set misaligned sticky, load pc unchanged, issue no requests until reset or an aligned redirect clears it.
REQ-032 SHALL, without FETCH_ALIGN_CHECK_EN, load pc <= {redirect_pc[31:2],2'b00} and tie misaligned to 0.

Verification
REQ-033 SHALL cover: reset, ready=1, rsp next cycle with data 32'h00000013 -> req addr 0x0, instr_valid with instruction 0x00000013, instr_pc 0x0; next req 0x4.
REQ-034 SHALL cover: instr_ready=0 stream -> exactly 2 instructions (pc 0x0, 0x4) buffered, mem_req_valid low until pop.
REQ-035 SHALL cover: redirect_pc=0x100 while WAIT_RSP -> late response discarded, next req addr 0x100, first instr_pc 0x100.
REQ-036 SHALL cover: mem_req_ready=0 for 5 cycles -> mem_req_valid high, addr stable at 0x0 throughout.
REQ-037 SHALL cover: redirect_pc=0x102 -> with FETCH_ALIGN_CHECK_EN misaligned=1 and no requests; without it req addr 0x100.
REQ-038 SHALL cover: reset asserted in WAIT_RSP with rsp arriving next cycle -> response ignored, FIFO empty, req addr RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a 2-entry
// instruction buffer. Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RSP,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;

  logic        fetch_block;
  logic [31:0] redirect_target;
  logic        req_valid;
  logic        req_fire;
  logic        push;
  logic        pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  assign fetch_block     = misaligned_q;
  assign redirect_target = redirect_pc;
  assign misaligned      = misaligned_q;
`else
  logic unused_redirect_lsbs;

  assign fetch_block          = 1'b0;
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign misaligned           = 1'b0;
  assign unused_redirect_lsbs = |redirect_pc[1:0];
`endif

  // Outstanding requests only exist outside IDLE, so count < 2 is the full credit test.
  assign req_valid = !reset && !redirect_valid && !fetch_block &&
                     (state_q == IDLE) && (count_q != 2'd2);
  assign req_fire  = req_valid && mem_req_ready;
  assign push      = (state_q == WAIT_RSP) && mem_rsp_valid;
  assign pop       = (count_q != 2'd0) && instr_ready;

  assign mem_req_valid = req_valid;
  assign mem_req_addr  = pc_q;
  assign instr_valid   = (count_q != 2'd0);
  assign instruction   = head_instr_q;
  assign instr_pc      = head_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif

    if (redirect_valid) begin
      pc_d    = redirect_target;
      count_d = 2'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned_d = |redirect_pc[1:0];
`endif
      // A response landing in the redirect cycle retires the outstanding request.
      case (state_q)
        WAIT_RSP, DROP: state_d = mem_rsp_valid ? IDLE : DROP;
        default:        state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            state_d    = WAIT_RSP;
            req_addr_d = pc_q;
            pc_d       = pc_q + 32'd4;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) state_d = IDLE;
        end
        DROP: begin
          if (mem_rsp_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Head slot drives the decoder directly; tail shifts into head on pop.
      case ({push, pop})
        2'b10: begin
          count_d = count_q + 2'd1;
          if (count_q == 2'd0) begin
            head_instr_d = mem_rsp_data;
            head_pc_d    = req_addr_q;
          end else begin
            tail_instr_d = mem_rsp_data;
            tail_pc_d    = req_addr_q;
          end
        end
        2'b01: begin
          count_d = count_q - 2'd1;
          if (count_q == 2'd2) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
          end
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_instr_d = mem_rsp_data;
            head_pc_d    = req_addr_q;
          end else begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            tail_instr_d = mem_rsp_data;
            tail_pc_d    = req_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= '0;
      count_q      <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: vector table, directed corner
// sequences, and a randomized run against a stream-level reference model.
module tb_instruction_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misaligned     (misaligned)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ir;
    logic        evr;
    logic [31:0] eaddr;
    logic        eiv;
    logic [31:0] einstr;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic ir, input logic evr, input logic [31:0] eaddr,
                              input logic eiv, input logic [31:0] einstr, input logic [31:0] epc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ir = ir;
    v.evr = evr; v.eaddr = eaddr; v.eiv = eiv; v.einstr = einstr; v.epc = epc;
    return v;
  endfunction

  // Memory contents as a pure function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic ir, input logic redir, input logic [31:0] rpc);
    mem_req_ready  = rdy;
    mem_rsp_valid  = rv;
    mem_rsp_data   = rdata;
    instr_ready    = ir;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk1 ("rst_req_valid",   mem_req_valid, 1'b0);
    chk1 ("rst_instr_valid", instr_valid,   1'b0);
    chk32("rst_instruction", instruction,   32'h0);
    chk32("rst_instr_pc",    instr_pc,      32'h0);
    chk1 ("rst_misaligned",  misaligned,    1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1 ("post_rst_req_valid", mem_req_valid, 1'b1);
    chk32("post_rst_req_addr",  mem_req_addr,  RPC);
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rdata,
                      input logic ir, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    drive(rdy, rv, rdata, ir, redir, rpc);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] exp_req, exp_pc, mem_addr, rpc;
    logic        mem_pend, busy, prev_redir, rdy, rv, ir, redir;
    logic [31:0] rdata;
    int unsigned mem_wait, consumed;

    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Single-cycle memory, decoder stalled until the buffer fills, then drained.
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0);
    vecs[1]  = mk(1'b1, 1'b1, 32'h13,       1'b0, 1'b0, 32'h4, 1'b0, 32'h0,        32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h4, 1'b1, 32'h13,       32'h0);
    vecs[3]  = mk(1'b1, 1'b1, 32'h00400093, 1'b0, 1'b0, 32'h8, 1'b1, 32'h13,       32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8, 1'b1, 32'h13,       32'h0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8, 1'b1, 32'h13,       32'h0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8, 1'b1, 32'h13,       32'h0);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8, 1'b1, 32'h00400093, 32'h4);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8, 1'b1, 32'h00400093, 32'h4);
    vecs[9]  = mk(1'b1, 1'b1, 32'h00800113, 1'b0, 1'b0, 32'hC, 1'b0, 32'h0,        32'h0);
    vecs[10] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC, 1'b1, 32'h00800113, 32'h8);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].ir, 1'b0, 32'h0);
      chk1 ($sformatf("vec%0d_req_valid", i),   mem_req_valid, vecs[i].evr);
      chk32($sformatf("vec%0d_req_addr", i),    mem_req_addr,  vecs[i].eaddr);
      chk1 ($sformatf("vec%0d_instr_valid", i), instr_valid,   vecs[i].eiv);
      if (vecs[i].eiv) begin
        chk32($sformatf("vec%0d_instruction", i), instruction, vecs[i].einstr);
        chk32($sformatf("vec%0d_instr_pc", i),    instr_pc,    vecs[i].epc);
      end
    end

    // Memory back-pressure: request held stable.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk1 ($sformatf("stall%0d_req_valid", i), mem_req_valid, 1'b1);
      chk32($sformatf("stall%0d_req_addr", i),  mem_req_addr,  32'h0);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk32("stall_release_addr", mem_req_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("stall_after_hs_valid", mem_req_valid, 1'b0);
    chk32("stall_after_hs_addr",  mem_req_addr,  32'h4);

    // Redirect while waiting: late response must be dropped.
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("rd_hs_valid", mem_req_valid, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    chk1 ("rd_cycle_no_req", mem_req_valid, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0);
    chk1 ("rd_drop_no_req", mem_req_valid, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("rd_no_stale_instr", instr_valid,   1'b0);
    chk1 ("rd_new_req_valid",  mem_req_valid, 1'b1);
    chk32("rd_new_req_addr",   mem_req_addr,  32'h100);
    step(1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("rd_first_valid", instr_valid, 1'b1);
    chk32("rd_first_pc",    instr_pc,    32'h100);
    chk32("rd_first_instr", instruction, 32'h13);

    // Misaligned redirect target.
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h102);
    chk1("mis_redirect_no_req", mem_req_valid, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk1($sformatf("mis%0d_flag", i),   misaligned,    1'b1);
      chk1($sformatf("mis%0d_no_req", i), mem_req_valid, 1'b0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("mis_clear_flag",  misaligned,    1'b0);
    chk1 ("mis_clear_valid", mem_req_valid, 1'b1);
    chk32("mis_clear_addr",  mem_req_addr,  32'h200);
`else
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("mis_flag_tied", misaligned,    1'b0);
    chk1 ("mis_req_valid", mem_req_valid, 1'b1);
    chk32("mis_req_addr",  mem_req_addr,  32'h100);
`endif

    // Reset while a request is outstanding; its response must be ignored.
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1("mrst_hs_valid", mem_req_valid, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0);
    #1;
    chk1 ("mrst_req_valid", mem_req_valid, 1'b1);
    chk32("mrst_req_addr",  mem_req_addr,  RPC);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk1 ("mrst_fifo_empty",  instr_valid,   1'b0);
    chk1 ("mrst_req_valid2",  mem_req_valid, 1'b1);
    chk32("mrst_req_addr2",   mem_req_addr,  RPC);

    // Randomized traffic: the consumed stream must be sequential from the
    // last redirect target, each word matching memory at its pc.
    do_reset();
    exp_req    = RPC;
    exp_pc     = RPC;
    mem_pend   = 1'b0;
    mem_wait   = 0;
    mem_addr   = 32'h0;
    prev_redir = 1'b0;
    consumed   = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      busy  = mem_pend;
      rv    = 1'b0;
      rdata = 32'h0;
      if (mem_pend) begin
        if (mem_wait <= 1) begin
          rv       = 1'b1;
          rdata    = mem_word(mem_addr);
          mem_pend = 1'b0;
        end else begin
          mem_wait--;
        end
      end
      rdy   = ($urandom_range(0, 3) != 0);
      ir    = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 24) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                          : ($urandom & 32'h0000_FFFC);
      drive(rdy, rv, rdata, ir, redir, rpc);
      #1;
      if (prev_redir) chk1("rnd_flush_after_redirect", instr_valid, 1'b0);
      if (redir) begin
        chk1("rnd_redirect_no_req", mem_req_valid, 1'b0);
        exp_req = rpc;
        exp_pc  = rpc;
      end else begin
        if (mem_req_valid && rdy) begin
          chk32("rnd_req_addr", mem_req_addr, exp_req);
          chk1 ("rnd_single_outstanding", busy, 1'b0);
          exp_req  = exp_req + 32'd4;
          mem_pend = 1'b1;
          mem_wait = $urandom_range(1, 3);
          mem_addr = mem_req_addr;
        end
        if (instr_valid && ir) begin
          chk32("rnd_instr_pc",   instr_pc,    exp_pc);
          chk32("rnd_instr_data", instruction, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
      end
      prev_redir = redir;
    end
    chk1("rnd_forward_progress", consumed > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
